// File: rtl/inta_sequencer.sv
// inta_sequencer: priority resolution, two-pulse INTA handshake, EOI/AEOI and
// priority rotation for an 8259-compatible interrupt controller.
module inta_sequencer #(
  parameter int SPURIOUS_LEVEL = 7,
  parameter int VEC_BASE_BITS  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IRR,
  input  logic [7:0] OCW1,
  input  logic [7:0] ICW2,
  input  logic       ICW4_AEOI,
  input  logic       rotate_on_aeoi,
  input  logic       INTA,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  input  logic       set_prio_valid,
  input  logic [2:0] set_prio_level,
  output logic       INT,
  output logic [7:0] ISR,
  output logic [7:0] clear_irr,
  output logic [7:0] vector_out,
  output logic       vector_oe,
  output logic [2:0] highest_priority_ISR
);
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, VEC} state_t;

  state_t     state;
  logic [2:0] lowest_priority;
  logic [2:0] lvl;          // level latched at the first INTA
  logic       spur;         // latched level is the spurious level
  logic       inta_prev;

  logic [7:0] req;
  logic       cand_found, isr_found, eligible;
  logic [2:0] cand_lvl, cand_rank, isr_lvl, isr_rank, pos;
  logic       fall, eoi_hit, aeoi_done;
  logic [2:0] eoi_tgt;
  logic [7:0] clr_mask, ack_set, isr_next;

  // Walk levels from lowest to highest priority so the last hit is the highest
  always_comb begin
    req        = IRR & ~OCW1;
    cand_found = 1'b0;
    cand_lvl   = '0;
    cand_rank  = '0;
    isr_found  = 1'b0;
    isr_lvl    = '0;
    isr_rank   = '0;
    pos        = '0;
    for (int i = 7; i >= 0; i--) begin
      pos = lowest_priority + 3'd1 + 3'(i);
      if (req[pos]) begin
        cand_found = 1'b1;
        cand_lvl   = pos;
        cand_rank  = 3'(i);
      end
      if (ISR[pos]) begin
        isr_found = 1'b1;
        isr_lvl   = pos;
        isr_rank  = 3'(i);
      end
    end
    // Fully nested: must outrank everything already in service
    eligible = cand_found && (!isr_found || (cand_rank < isr_rank));
  end

  // Next ISR: EOI/AEOI clears act on the pre-cycle ISR, then the acknowledge set wins
  always_comb begin
    fall    = inta_prev & ~INTA;
    eoi_hit = 1'b0;
    eoi_tgt = eoi_level;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_hit = 1'b1;
      end else begin
        eoi_hit = isr_found;
        eoi_tgt = isr_lvl;
      end
    end
    aeoi_done = (state == VEC) && INTA && ICW4_AEOI && !spur;
    clr_mask  = '0;
    ack_set   = '0;
    if (eoi_hit)   clr_mask[eoi_tgt] = 1'b1;
    if (aeoi_done) clr_mask[lvl]     = 1'b1;
    if ((state == IDLE) && fall && eligible) ack_set[cand_lvl] = 1'b1;
    isr_next = (ISR & ~clr_mask) | ack_set;
  end

  // Handshake FSM with registered outputs, ISR and rotation state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      INT             <= 1'b0;
      ISR             <= '0;
      clear_irr       <= '0;
      vector_out      <= '0;
      vector_oe       <= 1'b0;
      lowest_priority <= 3'd7;
      lvl             <= 3'(SPURIOUS_LEVEL);
      spur            <= 1'b0;
      inta_prev       <= 1'b1;
    end else begin
      inta_prev <= INTA;
      ISR       <= isr_next;
      clear_irr <= ack_set;
      INT       <= 1'b0;
      if (set_prio_valid)                 lowest_priority <= set_prio_level;
      else if (eoi_hit && eoi_rotate)     lowest_priority <= eoi_tgt;
      else if (aeoi_done && rotate_on_aeoi) lowest_priority <= lvl;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= ACK1;
            lvl   <= eligible ? cand_lvl : 3'(SPURIOUS_LEVEL);
            spur  <= !eligible;
          end else begin
            INT <= eligible;
          end
        end
        ACK1:  if (INTA) state <= WAIT2;
        WAIT2: begin
          if (fall) begin
            state      <= VEC;
            vector_out <= {ICW2[7 -: VEC_BASE_BITS], lvl};
            vector_oe  <= 1'b1;
          end
        end
        VEC: begin
          // further falling edges cannot occur here without a rise ending the cycle
          if (INTA) begin
            vector_oe <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign highest_priority_ISR = isr_lvl;

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Schedules interrupt service for the 8259-compatible PIC.
- Resolves priority among pending unmasked requests against the in-service set and raises INT.
- Runs the two-pulse INTA handshake: sets the ISR bit, clears the serviced IRR bit, drives the vector byte.
- Applies EOI, automatic EOI (AEOI) and priority-rotation commands decoded by the control logic.

Parameters:
SPURIOUS_LEVEL, 7, IR level reported in the vector when the request vanishes before the first INTA.
VEC_BASE_BITS, 5, number of vector bits taken from ICW2 (T7..T3); the level fills the low 3 bits.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
IRR  in  8  interrupt request register (edge/level handling is done upstream).
OCW1  in  8  interrupt mask; 1 = masked.
ICW2  in  8  vector base; only bits [7:3] are used.
ICW4_AEOI  in  1  automatic EOI enable.
rotate_on_aeoi  in  1  rotate priority on AEOI.
INTA  in  1  active-low acknowledge, already synchronous to clk.
eoi_valid  in  1  one-cycle EOI command strobe.
eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
eoi_level  in  3  level for specific EOI.
eoi_rotate  in  1  rotate priority on this EOI.
set_prio_valid  in  1  one-cycle set-priority strobe.
set_prio_level  in  3  new lowest-priority level.
INT  out  1  interrupt request to the CPU.
ISR  out  8  in-service register.
clear_irr  out  8  one-hot, one-cycle pulse that clears the serviced IRR bit.
vector_out  out  8  vector byte.
vector_oe  out  1  data-bus drive enable for vector_out.
highest_priority_ISR  out  3  highest-priority level currently in service (valid when ISR != 0).

Behaviour:
- Reset values: INT=0, ISR=0, clear_irr=0, vector_out=0, vector_oe=0, lowest_priority=7, state=IDLE. Reset takes effect immediately, including mid-handshake.
- Priority order: level (lowest_priority+1) mod 8 is highest, wrapping down to lowest_priority. At reset IR0 is highest and IR7 is lowest.
- Candidate: highest-priority bit of IRR & ~OCW1.
- Fully nested rule: the candidate is eligible only if it has strictly higher priority than every set ISR bit.
- INTA falling edge is detected as INTA_prev=1 and INTA=0, registered once per clk.
- State IDLE:
  - INT <= 1 whenever an eligible candidate exists, otherwise 0.
  - INTA falling edge -> ACK1.
- Entering ACK1 (same clk edge as the falling edge):
  - Latch lvl = current eligible candidate, set ISR[lvl], pulse clear_irr[lvl] for exactly 1 cycle, INT <= 0.
  - If no eligible candidate exists: lvl = SPURIOUS_LEVEL, no ISR set, no clear_irr pulse.
- State ACK1: stays until INTA = 1, then -> WAIT2.
- State WAIT2: on INTA falling edge -> VEC. On the same edge, vector_out <= {ICW2[7:3], lvl} and vector_oe <= 1.
- State VEC: vector_oe stays high while INTA = 0. On INTA = 1:
  - vector_oe <= 0 and go to IDLE.
  - If ICW4_AEOI and the level was not spurious: clear ISR[lvl]; if rotate_on_aeoi, lowest_priority <= lvl.
- Latency: INT rises 1 clk after an eligible request appears. The vector is driven 1 clk after the second INTA falling edge.
- Non-specific EOI: clears the highest-priority set ISR bit. If ISR = 0 there is no effect. If eoi_rotate, lowest_priority <= the cleared level.
- Specific EOI: clears ISR[eoi_level]. If eoi_rotate, lowest_priority <= eoi_level.
- set_prio_valid: lowest_priority <= set_prio_level. If both rotation and set_prio_valid occur in the same cycle, set_prio_valid wins.
- EOI and the ISR set in the same cycle:
  - The EOI target is computed from the pre-cycle ISR.
  - The clear applies first, then the set.
  - If both address the same bit, the set wins.
- EOI is accepted in any state. INT re-evaluation after an EOI occurs only in IDLE.
- A third INTA falling edge before the return to IDLE is ignored.

Test Plan:
- ICW2=0x08, IRR=0x60, OCW1=0x00, two INTA pulses -> INT=1; ISR=0x20; clear_irr=0x20 for 1 cycle; vector_out=0x0D with vector_oe high during the second INTA low; INT falls after the first INTA.
- ISR=0x20, then IRR=0x80 -> INT stays 0 (IR7 lower than IR5). Then IRR=0x08 -> INT=1. Then non-specific EOI -> ISR bit 3 cleared first (highest-priority bit).
- ICW4_AEOI=1, rotate_on_aeoi=1, IRR=0x01, full handshake -> ISR returns to 0 when the second INTA rises; lowest_priority=0, so IR1 now has highest priority.
- IRR=0x04 raises INT; IRR drops to 0 before the first INTA -> vector_out={ICW2[7:3],3'd7}; ISR=0; no clear_irr pulse.
- Masking and set-priority: OCW1=0xFF with IRR=0xFF -> INT=0. Then set_prio_level=3 with OCW1=0x00, IRR=0x11 -> first ISR set is bit 4.
- Reset asserted in WAIT2 -> all outputs return to reset values within the same cycle; the next INTA pulse without a request is treated as the first INTA.
